// File: rtl/mux_stream_nto1.sv
// rtl/mux_stream_nto1.sv - N:1 registered valid/ready stream mux, fixed-select or round-robin; packet lock under MUX_PKT_LOCK_EN
module mux_stream_nto1 #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    localparam int SEL_W = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
`ifdef MUX_PKT_LOCK_EN
    input  logic [NUM_CH-1:0]        in_last,
`endif
    output logic [NUM_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
`ifdef MUX_PKT_LOCK_EN
    output logic                     out_last,
`endif
    input  logic                     out_ready
);

    logic [SEL_W-1:0]  rr_ptr;
    logic              locked;
    logic [SEL_W-1:0]  lock_ch;
    logic              can_load;
    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic [DATA_W-1:0] grant_data;
    logic              xfer;

    assign can_load = !out_valid || out_ready;

    // Grant priority: an open packet wins over both selection modes.
    always_comb begin
        int  idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        idx       = 0;
        found     = 1'b0;
        if (locked) begin
            grant[lock_ch] = 1'b1;
            grant_idx      = lock_ch;
        end else if (!mode) begin
            if (int'(sel) < NUM_CH) begin
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end else begin
            for (int j = 0; j < NUM_CH; j++) begin
                idx = int'(rr_ptr) + j;
                if (idx >= NUM_CH)
                    idx = idx - NUM_CH;
                if (!found && in_valid[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    grant_idx  = SEL_W'(idx);
                end
            end
        end
    end

    // AND-OR select keeps the data path free of out_ready.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i])
                grant_data = grant_data | in_data[i*DATA_W +: DATA_W];
        end
    end

    assign in_ready = rst_n ? (grant & {NUM_CH{can_load}}) : '0;
    assign xfer     = |(in_valid & in_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else begin
            if (can_load) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= grant_data;
                    out_ch   <= grant_idx;
                end
            end
            if (xfer && mode)
                rr_ptr <= (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

`ifdef MUX_PKT_LOCK_EN
    logic xfer_last;
    assign xfer_last = in_last[grant_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            locked   <= 1'b0;
            lock_ch  <= '0;
            out_last <= 1'b0;
        end else if (xfer) begin
            locked   <= !xfer_last;
            lock_ch  <= grant_idx;
            out_last <= xfer_last;
        end
    end
`else
    assign locked  = 1'b0;
    assign lock_ch = '0;
`endif

endmodule
